key_event_decoder: RTL
======================

# key_event_decoder

Classifies a debounced push-button level into discrete user events: single click, double click, long press and auto-repeat while held. It sits directly downstream of the button debouncer and consumes its debounced level output, where 0 means pressed. Its registered one-cycle event pulses drive UI logic such as menu stepping and mode toggling.

## Interface
Parameters:
- `LONG_CYC`, 50_000_000: cycles a first press must be held to count as a long press (1 s @ 50 MHz). Must be ≥ 2.
- `DBL_CYC`, 15_000_000: window after the first release in which a second press makes a double click. Must be ≥ 2.
- `REPEAT_CYC`, 10_000_000: auto-repeat period while in HOLD. A value of 0 disables repeat.
- `CNT_W`, 26: counter width. Must satisfy 2^CNT_W > max(LONG_CYC, DBL_CYC, REPEAT_CYC).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset. The block has one clock; reset is synchronous and active-high.
- `key_db_n` in 1: debounced key level; 0 = pressed. Already synchronous to `clk`.
- `single_click` out 1: one-cycle pulse.
- `double_click` out 1: one-cycle pulse.
- `long_press` out 1: one-cycle pulse.
- `repeat_tick` out 1: one-cycle pulse, one per repeat period in HOLD.
- `evt_valid` out 1: high in the same cycle as any event pulse.
- `evt_code` out 2: event code, valid when `evt_valid`=1: 00 single, 01 double, 10 long, 11 repeat. Holds its last value otherwise.
- `busy` out 1: high when the state is not IDLE.

## Operation
- State machine: IDLE, PRESS1, WAIT2, PRESS2, HOLD. There is one shared counter `cnt[CNT_W-1:0]`, cleared to 0 on every state change.
- **IDLE**: if `key_db_n`=0, go to PRESS1.
- **PRESS1**: `cnt` increments each cycle.
  - If `key_db_n`=1, go to WAIT2.
  - Else if `cnt`==LONG_CYC-1, pulse `long_press` and go to HOLD.
- **WAIT2**: `cnt` increments each cycle.
  - If `key_db_n`=0, go to PRESS2.
  - Else if `cnt`==DBL_CYC-1, pulse `single_click` and go to IDLE.
- **PRESS2**: no counting. On `key_db_n`=1, pulse `double_click` and go to IDLE. A long hold in PRESS2 produces no long or repeat event.
- **HOLD**: if `key_db_n`=1, go to IDLE with no event.
  - Else, if REPEAT_CYC≠0, `cnt` increments; when `cnt`==REPEAT_CYC-1, pulse `repeat_tick` and clear `cnt`.
- Simultaneous events are resolved in favour of the key:
  - Release on the cycle `cnt`==LONG_CYC-1 in PRESS1 means release wins: WAIT2, no `long_press`.
  - Press on the cycle `cnt`==DBL_CYC-1 in WAIT2 means press wins: PRESS2, no `single_click`.
- At most one event pulse is high in any cycle. `evt_valid` is the OR of the four pulses, and `evt_code` is registered alongside them.
- Counter arithmetic is unsigned and never wraps. Every comparison fires before overflow, given the CNT_W rule.

## Timing
- All outputs are registered. Reset values: state IDLE, `cnt`=0, all pulses 0, `evt_valid`=0, `evt_code`=00, `busy`=0.
- Reset mid-operation drops any pending event; nothing is emitted. If the key is still held when `rst` deasserts, the first edge goes to PRESS1 and counting starts from 0.
- Edge E0 is the first edge at which IDLE samples `key_db_n`=0. After E0 the state is PRESS1 with `cnt`=0, and `busy` rises after E0.
- Long press: with the key held, `long_press` is high in the cycle after edge E(LONG_CYC), i.e. LONG_CYC cycles after entering PRESS1.
- Single click: `single_click` is high DBL_CYC cycles after entering WAIT2.
- Double click: `double_click` is high in the cycle after the edge that samples the release in PRESS2.
- Repeat: the first `repeat_tick` comes REPEAT_CYC cycles after entering HOLD, then every REPEAT_CYC cycles.
- Each pulse is exactly 1 cycle wide. `busy` falls in the same cycle as the final event pulse, or one cycle after the release edge when leaving HOLD.

## Test plan
All tests use LONG_CYC=20, DBL_CYC=10, REPEAT_CYC=8, CNT_W=8.
- Press 5 cycles, release, idle 30 -> one `single_click` exactly 10 cycles after WAIT2 entry; `evt_code`=00; no other pulses.
- Press 5, release 4, press 5, release -> `double_click` 1 cycle after the second release is sampled; `evt_code`=01; no `single_click`.
- Hold 40 cycles, then release -> `long_press` 20 cycles after PRESS1 entry and `repeat_tick` at +28 and +36 (`evt_code`=11). On release: `busy` low, no click events.
- Boundaries:
  - Release sampled exactly when `cnt`=19 in PRESS1 -> no `long_press`; `single_click` follows 10 cycles later.
  - Press sampled when `cnt`=9 in WAIT2 -> PRESS2, no `single_click`.
- Assert `rst` for 1 cycle at PRESS1 `cnt`=10 with the key held -> all outputs 0. After `rst` deasserts, `long_press` occurs 20 cycles after the new PRESS1 entry.
- REPEAT_CYC=0, hold 60 cycles -> a single `long_press` and no `repeat_tick`.

Source files
------------

// File: rtl/key_event_decoder.sv
// Turns a debounced active-low button level into single/double click,
// long-press and auto-repeat events, each a registered one-cycle pulse.
module key_event_decoder #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned DBL_CYC    = 15_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_db_n,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_tick,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [1:0] CODE_SINGLE = 2'b00;
  localparam logic [1:0] CODE_DOUBLE = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_REPEAT = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  // REPEAT_CYC of 0 turns repeat off; keep the terminal count well-defined anyway
  localparam logic [CNT_W-1:0] REP_LAST  =
    (REPEAT_CYC == 0) ? '0 : CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             single_q, double_q, long_q, repeat_q, valid_q, busy_q;
  logic [1:0]       code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= CODE_SINGLE;
      busy_q   <= 1'b0;
    end else begin
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!key_db_n) begin
            state_q <= PRESS1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        PRESS1: begin
          // key edges take priority over the timeout on the same cycle
          if (key_db_n) begin
            state_q <= WAIT2;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
            valid_q <= 1'b1;
            code_q  <= CODE_LONG;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        WAIT2: begin
          if (!key_db_n) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == DBL_LAST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b1;
            valid_q  <= 1'b1;
            code_q   <= CODE_SINGLE;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESS2: begin
          if (key_db_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            double_q <= 1'b1;
            valid_q  <= 1'b1;
            code_q   <= CODE_DOUBLE;
            busy_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (key_db_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (REPEAT_CYC != 0) begin
            if (cnt_q == REP_LAST) begin
              cnt_q    <= '0;
              repeat_q <= 1'b1;
              valid_q  <= 1'b1;
              code_q   <= CODE_REPEAT;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_tick  = repeat_q;
  assign evt_valid    = valid_q;
  assign evt_code     = code_q;
  assign busy         = busy_q;

endmodule
